// File: rtl/snn_cmd_dispatch.sv
// snn_cmd_dispatch
//   Bridges the EX-stage SNN strobes to the SNN accelerator request/response
//   handshake, buffers one result, stalls the CPU pipeline while a strobe
//   cannot yet be honoured, and pushes results toward the data-stack write path.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   ctrl_valid, funct_op start strobe; funct_op selects PRE/ENC/SNN
//   enc_sel              encoder select latched with a start
//   clear, wait_snn,     remaining EX strobes
//   output_snn
//   T, N                 data stack top/next, latched as rs1/rs2
//   cpu_stall            combinational pipeline hold
//   res_push, res_data   registered 1-cycle push pulse and its data
//   busy                 FSM not idle
//   err_flags            sticky {overwrite, timeout, rsp_err}
//   snn_req_*            request channel to the accelerator
//   snn_abort            1-cycle abort pulse
//   snn_rsp_*            response channel from the accelerator
//
// funct_op start encodings: START_PRE=4'h1, START_ENC=4'h2, START_SNN=4'h3.
// Optional feature macro: SNN_TIMEOUT_EN (BUSY timeout after TIMEOUT_CYCLES).
module snn_cmd_dispatch #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_valid,
  input  logic [3:0]            funct_op,
  input  logic [1:0]            enc_sel,
  input  logic                  clear,
  input  logic                  wait_snn,
  input  logic                  output_snn,
  input  logic [DATA_WIDTH-1:0] T,
  input  logic [DATA_WIDTH-1:0] N,
  output logic                  cpu_stall,
  output logic                  res_push,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic [2:0]            err_flags,
  output logic                  snn_req_valid,
  input  logic                  snn_req_ready,
  output logic [1:0]            snn_req_type,
  output logic [1:0]            snn_req_enc,
  output logic [DATA_WIDTH-1:0] snn_req_rs1,
  output logic [DATA_WIDTH-1:0] snn_req_rs2,
  output logic                  snn_abort,
  input  logic                  snn_rsp_valid,
  output logic                  snn_rsp_ready,
  input  logic [DATA_WIDTH-1:0] snn_rsp_data,
  input  logic                  snn_rsp_err
);

  localparam logic [3:0] START_PRE = 4'h1;
  localparam logic [3:0] START_ENC = 4'h2;
  localparam logic [3:0] START_SNN = 4'h3;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  req_valid_q, req_valid_d;
  logic [1:0]            req_type_q, req_type_d;
  logic [1:0]            req_enc_q, req_enc_d;
  logic [DATA_WIDTH-1:0] req_rs1_q, req_rs1_d;
  logic [DATA_WIDTH-1:0] req_rs2_q, req_rs2_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_push_q, res_push_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [2:0]            err_q, err_d;
  logic                  abort_q, abort_d;

  logic                  start_known;
  logic [1:0]            start_type;
  logic                  capture;
  logic                  consume;

`ifdef SNN_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_type_d  = req_type_q;
    req_enc_d   = req_enc_q;
    req_rs1_d   = req_rs1_q;
    req_rs2_d   = req_rs2_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    res_push_d  = 1'b0;
    res_data_d  = res_data_q;
    err_d       = err_q;
    abort_d     = 1'b0;
    cpu_stall   = 1'b0;
    capture     = 1'b0;
    start_known = 1'b1;
    start_type  = 2'b00;
`ifdef SNN_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (funct_op)
      START_PRE: start_type = 2'b00;
      START_ENC: start_type = 2'b01;
      START_SNN: start_type = 2'b10;
      default:   start_known = 1'b0;
    endcase

    // Accelerator-side progression runs regardless of which strobe is active.
    case (state_q)
      REQ: begin
        if (snn_req_ready) begin
          state_d     = BUSY;
          req_valid_d = 1'b0;
`ifdef SNN_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        if (snn_rsp_valid) begin
          state_d  = IDLE;
          result_d = snn_rsp_data;
          capture  = 1'b1;
          err_d[0] = err_q[0] | snn_rsp_err;
        end
`ifdef SNN_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = IDLE;
          result_d = '1;
          capture  = 1'b1;
          abort_d  = 1'b1;
          err_d[1] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase

    // A result read out in the same cycle a new one lands is not an overwrite.
    consume = !clear && output_snn && res_valid_q;
    if (consume) begin
      res_push_d  = 1'b1;
      res_data_d  = result_q;
      res_valid_d = 1'b0;
    end
    if (capture) begin
      if (res_valid_q && !consume) begin
        err_d[2] = 1'b1;
      end
      res_valid_d = 1'b1;
    end

    if (clear) begin
      state_d     = IDLE;
      req_valid_d = 1'b0;
      res_valid_d = 1'b0;
      err_d       = '0;
      abort_d     = (state_q != IDLE);
`ifdef SNN_TIMEOUT_EN
      cnt_d       = '0;
`endif
    end else if (output_snn) begin
      if (!res_valid_q && (state_q != IDLE)) begin
        cpu_stall = 1'b1;
      end else if (!res_valid_q) begin
        res_push_d = 1'b1;
        res_data_d = '0;
        err_d[0]   = 1'b1;
      end
    end else if (ctrl_valid) begin
      if (state_q != IDLE) begin
        cpu_stall = 1'b1;
      end else if (start_known) begin
        state_d     = REQ;
        req_valid_d = 1'b1;
        req_type_d  = start_type;
        req_enc_d   = enc_sel;
        req_rs1_d   = T;
        req_rs2_d   = N;
      end
    end else if (wait_snn) begin
      cpu_stall = (state_q != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_type_q  <= '0;
      req_enc_q   <= '0;
      req_rs1_q   <= '0;
      req_rs2_q   <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      res_push_q  <= 1'b0;
      res_data_q  <= '0;
      err_q       <= '0;
      abort_q     <= 1'b0;
`ifdef SNN_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_type_q  <= req_type_d;
      req_enc_q   <= req_enc_d;
      req_rs1_q   <= req_rs1_d;
      req_rs2_q   <= req_rs2_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      res_push_q  <= res_push_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
`ifdef SNN_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign res_push      = res_push_q;
  assign res_data      = res_data_q;
  assign busy          = (state_q != IDLE);
  assign err_flags     = err_q;
  assign snn_req_valid = req_valid_q;
  assign snn_req_type  = req_type_q;
  assign snn_req_enc   = req_enc_q;
  assign snn_req_rs1   = req_rs1_q;
  assign snn_req_rs2   = req_rs2_q;
  assign snn_abort     = abort_q;
  assign snn_rsp_ready = (state_q == BUSY);

endmodule

// File: tb/tb_snn_cmd_dispatch.sv
// Self-checking bench for snn_cmd_dispatch: directed scenarios plus a
// randomized transaction loop scored against a transaction-level model
// (sticky error bits, one-deep result buffer, expected push count).
module tb_snn_cmd_dispatch;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;
  localparam logic [3:0] F_PRE = 4'h1;
  localparam logic [3:0] F_ENC = 4'h2;
  localparam logic [3:0] F_SNN = 4'h3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ctrl_valid, clear, wait_snn, output_snn;
  logic [3:0]    funct_op;
  logic [1:0]    enc_sel;
  logic [DW-1:0] T, N;
  logic          cpu_stall, res_push, busy;
  logic [DW-1:0] res_data;
  logic [2:0]    err_flags;
  logic          snn_req_valid, snn_req_ready;
  logic [1:0]    snn_req_type, snn_req_enc;
  logic [DW-1:0] snn_req_rs1, snn_req_rs2;
  logic          snn_abort, snn_rsp_valid, snn_rsp_ready, snn_rsp_err;
  logic [DW-1:0] snn_rsp_data;

  int unsigned passed = 0;
  int unsigned total = 0;
  int unsigned push_seen = 0;
  int unsigned push_exp = 0;

  // transaction-level model
  logic [DW-1:0] m_result;
  logic          m_pending;
  logic [2:0]    m_err;

  snn_cmd_dispatch #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .funct_op(funct_op),
    .enc_sel(enc_sel), .clear(clear), .wait_snn(wait_snn), .output_snn(output_snn),
    .T(T), .N(N), .cpu_stall(cpu_stall), .res_push(res_push), .res_data(res_data),
    .busy(busy), .err_flags(err_flags), .snn_req_valid(snn_req_valid),
    .snn_req_ready(snn_req_ready), .snn_req_type(snn_req_type), .snn_req_enc(snn_req_enc),
    .snn_req_rs1(snn_req_rs1), .snn_req_rs2(snn_req_rs2), .snn_abort(snn_abort),
    .snn_rsp_valid(snn_rsp_valid), .snn_rsp_ready(snn_rsp_ready),
    .snn_rsp_data(snn_rsp_data), .snn_rsp_err(snn_rsp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_push === 1'b1) push_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ctrl_valid = 1'b0; funct_op = '0; enc_sel = '0; clear = 1'b0;
    wait_snn = 1'b0; output_snn = 1'b0; T = '0; N = '0;
    snn_req_ready = 1'b0; snn_rsp_valid = 1'b0; snn_rsp_data = '0; snn_rsp_err = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_err = '0;
    m_pending = 1'b0;
  endtask

  task automatic go_busy(input logic [3:0] f, input logic [1:0] e,
                         input logic [DW-1:0] t, input logic [DW-1:0] n);
    ctrl_valid = 1'b1; funct_op = f; enc_sel = e; T = t; N = n;
    tick();
    ctrl_valid = 1'b0; snn_req_ready = 1'b1;
    tick();
    snn_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] d, input logic e);
    snn_rsp_valid = 1'b1; snn_rsp_data = d; snn_rsp_err = e;
    tick();
    snn_rsp_valid = 1'b0; snn_rsp_err = 1'b0;
    if (m_pending) m_err[2] = 1'b1;
    m_pending = 1'b1;
    m_result  = d;
    m_err[0]  = m_err[0] | e;
  endtask

  task automatic test_reset();
    logic [11:0] flat;
    rst_n = 1'b0;
    drive_idle();
    tick(); tick();
    flat = {busy, cpu_stall, res_push, err_flags, snn_req_valid, snn_req_type,
            snn_req_enc, snn_abort};
    total++;
    if (flat !== 12'h000 || snn_rsp_ready !== 1'b0)
      $display("FAIL reset_ctrl: got %h/%b want 000/0", flat, snn_rsp_ready);
    else passed++;
    total++;
    if ({res_data, snn_req_rs1, snn_req_rs2} !== {3{16'h0000}})
      $display("FAIL reset_data: got %h %h %h want 0 0 0", res_data, snn_req_rs1, snn_req_rs2);
    else passed++;

    // mid-operation reset with a buffered result and a request in flight
    rst_n = 1'b1;
    tick();
    go_busy(F_SNN, 2'b01, 16'h1111, 16'h2222);
    respond(16'h1234, 1'b1);
    ctrl_valid = 1'b1; funct_op = F_ENC;
    tick();
    ctrl_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    flat = {busy, cpu_stall, res_push, err_flags, snn_req_valid, snn_req_type,
            snn_req_enc, snn_abort};
    total++;
    if (flat !== 12'h000 || snn_req_rs1 !== 16'h0000)
      $display("FAIL midop_reset: got %h rs1=%h want 000 rs1=0000", flat, snn_req_rs1);
    else passed++;
    rst_n = 1'b1;
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data, err_flags} !== {1'b1, 16'h0000, 3'b001})
      $display("FAIL reset_clears_result: got %b %h %b want 1 0000 001", res_push, res_data, err_flags);
    else passed++;
    do_clear();
  endtask

  task automatic test_start_snn();
    ctrl_valid = 1'b1; funct_op = F_SNN; enc_sel = 2'b10; T = 16'h0012; N = 16'h0034;
    tick();
    ctrl_valid = 1'b0;
    total++;
    if ({snn_req_valid, snn_req_type, snn_req_rs1, snn_req_rs2, busy} !== {1'b1, 2'b10, 16'h0012, 16'h0034, 1'b1})
      $display("FAIL start_req: got v=%b t=%b rs1=%h rs2=%h want 1 10 0012 0034",
               snn_req_valid, snn_req_type, snn_req_rs1, snn_req_rs2);
    else passed++;
    for (int unsigned k = 0; k < 3; k++) begin
      T = DW'($urandom); N = DW'($urandom); enc_sel = 2'($urandom);
      tick();
      total++;
      if ({snn_req_valid, snn_req_type, snn_req_enc, snn_req_rs1, snn_req_rs2} !==
          {1'b1, 2'b10, 2'b10, 16'h0012, 16'h0034})
        $display("FAIL req_hold: got v=%b rs1=%h rs2=%h enc=%b want 1 0012 0034 10",
                 snn_req_valid, snn_req_rs1, snn_req_rs2, snn_req_enc);
      else passed++;
    end
    snn_req_ready = 1'b1;
    tick();
    snn_req_ready = 1'b0;
    total++;
    if ({busy, snn_rsp_ready, snn_req_valid} !== 3'b110)
      $display("FAIL enter_busy: got busy/rsp_ready/req_valid=%b%b%b want 110", busy, snn_rsp_ready, snn_req_valid);
    else passed++;
    snn_rsp_valid = 1'b1; snn_rsp_data = 16'h5A5A; snn_rsp_err = 1'b0;
    tick();
    snn_rsp_valid = 1'b0;
    output_snn = 1'b1;
    #1;
    total++;
    if ({busy, cpu_stall, snn_rsp_ready} !== 3'b000)
      $display("FAIL rsp_to_idle: got busy/stall/rsp_ready=%b%b%b want 000", busy, cpu_stall, snn_rsp_ready);
    else passed++;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data, err_flags} !== {1'b1, 16'h5A5A, 3'b000})
      $display("FAIL push_5a5a: got %b %h %b want 1 5a5a 000", res_push, res_data, err_flags);
    else passed++;
    tick();
    total++;
    if (res_push !== 1'b0) $display("FAIL push_pulse_width: got %b want 0", res_push);
    else passed++;
  endtask

  task automatic test_wait_stall();
    int unsigned stalls = 0;
    go_busy(F_PRE, 2'b00, 16'hAAAA, 16'h5555);
    wait_snn = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      #1;
      if (cpu_stall === 1'b1) stalls++;
      if (i == 9) begin snn_rsp_valid = 1'b1; snn_rsp_data = 16'h0C0C; end
      tick();
    end
    snn_rsp_valid = 1'b0;
    #1;
    total++;
    if (stalls != 10) $display("FAIL wait_stall_cycles: got %0d want 10", stalls);
    else passed++;
    total++;
    if ({cpu_stall, busy} !== 2'b00)
      $display("FAIL wait_release: got stall/busy=%b%b want 00", cpu_stall, busy);
    else passed++;
    wait_snn = 1'b0;
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data} !== {1'b1, 16'h0C0C})
      $display("FAIL wait_push: got %b %h want 1 0c0c", res_push, res_data);
    else passed++;
  endtask

  task automatic test_output_in_req();
    int unsigned stalls = 0;
    ctrl_valid = 1'b1; funct_op = F_ENC; enc_sel = 2'b11; T = 16'h0101; N = 16'h0202;
    tick();
    ctrl_valid = 1'b0;
    total++;
    if ({snn_req_type, snn_req_enc} !== 4'b0111)
      $display("FAIL enc_req: got type=%b enc=%b want 01 11", snn_req_type, snn_req_enc);
    else passed++;
    output_snn = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      snn_req_ready = (c == 2);
      snn_rsp_valid = (c == 5); snn_rsp_data = 16'h0007; snn_rsp_err = 1'b1;
      #1;
      if (cpu_stall === 1'b1) stalls++;
      tick();
    end
    snn_req_ready = 1'b0; snn_rsp_valid = 1'b0; snn_rsp_err = 1'b0;
    #1;
    total++;
    if (stalls != 6 || cpu_stall !== 1'b0)
      $display("FAIL output_stall: got %0d cycles then %b want 6 then 0", stalls, cpu_stall);
    else passed++;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data, err_flags} !== {1'b1, 16'h0007, 3'b001})
      $display("FAIL push_0007: got %b %h %b want 1 0007 001", res_push, res_data, err_flags);
    else passed++;
    do_clear();
  endtask

  task automatic test_clear();
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data, err_flags} !== {1'b1, 16'h0000, 3'b001})
      $display("FAIL empty_output: got %b %h %b want 1 0000 001", res_push, res_data, err_flags);
    else passed++;
    go_busy(F_SNN, 2'b00, 16'h3333, 16'h4444);
    clear = 1'b1;
    #1;
    total++;
    if (cpu_stall !== 1'b0) $display("FAIL clear_stall: got %b want 0", cpu_stall);
    else passed++;
    tick();
    clear = 1'b0;
    total++;
    if ({snn_abort, busy, err_flags, snn_rsp_ready} !== {1'b1, 1'b0, 3'b000, 1'b0})
      $display("FAIL clear_busy: got abort=%b busy=%b err=%b rdy=%b want 1 0 000 0",
               snn_abort, busy, err_flags, snn_rsp_ready);
    else passed++;
    snn_rsp_valid = 1'b1; snn_rsp_data = 16'hBEEF;
    tick();
    snn_rsp_valid = 1'b0;
    total++;
    if ({snn_abort, busy} !== 2'b00)
      $display("FAIL abort_pulse: got abort=%b busy=%b want 0 0", snn_abort, busy);
    else passed++;
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data, err_flags} !== {1'b1, 16'h0000, 3'b001})
      $display("FAIL late_rsp_ignored: got %b %h %b want 1 0000 001", res_push, res_data, err_flags);
    else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({snn_abort, err_flags} !== 4'b0000)
      $display("FAIL clear_idle: got abort=%b err=%b want 0 000", snn_abort, err_flags);
    else passed++;
    ctrl_valid = 1'b1; funct_op = F_PRE;
    tick();
    ctrl_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({snn_abort, snn_req_valid, busy} !== 3'b100)
      $display("FAIL clear_req: got abort=%b req_valid=%b busy=%b want 1 0 0", snn_abort, snn_req_valid, busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_clear();
    ctrl_valid = 1'b1; funct_op = F_SNN; enc_sel = 2'b01; T = 16'h00A1; N = 16'h00B2;
    tick();
    funct_op = F_PRE; enc_sel = 2'b10; T = 16'h0C3C; N = 16'h0D4D;
    #1;
    total++;
    if ({cpu_stall, snn_req_rs1} !== {1'b1, 16'h00A1})
      $display("FAIL b2b_stall_req: got stall=%b rs1=%h want 1 00a1", cpu_stall, snn_req_rs1);
    else passed++;
    snn_req_ready = 1'b1;
    tick();
    snn_req_ready = 1'b0;
    #1;
    total++;
    if (cpu_stall !== 1'b1) $display("FAIL b2b_stall_busy: got %b want 1", cpu_stall);
    else passed++;
    snn_rsp_valid = 1'b1; snn_rsp_data = 16'h1357;
    tick();
    snn_rsp_valid = 1'b0;
    #1;
    total++;
    if (cpu_stall !== 1'b0) $display("FAIL b2b_release: got %b want 0", cpu_stall);
    else passed++;
    tick();
    ctrl_valid = 1'b0;
    total++;
    if ({busy, snn_req_valid, snn_req_type, snn_req_enc, snn_req_rs1, snn_req_rs2} !==
        {1'b1, 1'b1, 2'b00, 2'b10, 16'h0C3C, 16'h0D4D})
      $display("FAIL b2b_second_req: got v=%b t=%b e=%b rs1=%h rs2=%h want 1 00 10 0c3c 0d4d",
               snn_req_valid, snn_req_type, snn_req_enc, snn_req_rs1, snn_req_rs2);
    else passed++;
    snn_req_ready = 1'b1;
    tick();
    snn_req_ready = 1'b0;
    snn_rsp_valid = 1'b1; snn_rsp_data = 16'h2468;
    tick();
    snn_rsp_valid = 1'b0;
    total++;
    if (err_flags !== 3'b100) $display("FAIL overwrite_flag: got %b want 100", err_flags);
    else passed++;
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data} !== {1'b1, 16'h2468})
      $display("FAIL overwrite_data: got %b %h want 1 2468", res_push, res_data);
    else passed++;
    do_clear();
  endtask

  task automatic test_unknown_and_priority();
    logic [3:0] f;
    for (int unsigned k = 0; k < 3; k++) begin
      f = (k == 0) ? 4'h0 : 4'($urandom_range(4, 15));
      ctrl_valid = 1'b1; funct_op = f;
      tick();
      ctrl_valid = 1'b0;
      total++;
      if ({busy, snn_req_valid} !== 2'b00)
        $display("FAIL unknown_funct_%h: got busy=%b req_valid=%b want 0 0", f, busy, snn_req_valid);
      else passed++;
    end
    go_busy(F_PRE, 2'b00, 16'h0001, 16'h0002);
    respond(16'h1111, 1'b0);
    clear = 1'b1; output_snn = 1'b1; ctrl_valid = 1'b1; funct_op = F_SNN; wait_snn = 1'b1;
    #1;
    total++;
    if (cpu_stall !== 1'b0) $display("FAIL prio_clear_stall: got %b want 0", cpu_stall);
    else passed++;
    tick();
    clear = 1'b0; output_snn = 1'b0; ctrl_valid = 1'b0; wait_snn = 1'b0;
    total++;
    if ({res_push, busy, snn_abort, snn_req_valid} !== 4'b0000)
      $display("FAIL prio_clear: got push=%b busy=%b abort=%b req=%b want 0000",
               res_push, busy, snn_abort, snn_req_valid);
    else passed++;
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data, err_flags} !== {1'b1, 16'h0000, 3'b001})
      $display("FAIL prio_clear_dropped: got %b %h %b want 1 0000 001", res_push, res_data, err_flags);
    else passed++;
    go_busy(F_ENC, 2'b01, 16'h0003, 16'h0004);
    respond(16'h2222, 1'b0);
    output_snn = 1'b1; ctrl_valid = 1'b1; funct_op = F_ENC;
    tick();
    output_snn = 1'b0; ctrl_valid = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data, busy} !== {1'b1, 16'h2222, 1'b0})
      $display("FAIL prio_output: got %b %h busy=%b want 1 2222 0", res_push, res_data, busy);
    else passed++;
    ctrl_valid = 1'b1; funct_op = F_SNN; wait_snn = 1'b1;
    #1;
    total++;
    if (cpu_stall !== 1'b0) $display("FAIL prio_start_stall: got %b want 0", cpu_stall);
    else passed++;
    tick();
    ctrl_valid = 1'b0; wait_snn = 1'b0;
    total++;
    if ({busy, snn_req_valid, snn_req_type} !== {1'b1, 1'b1, 2'b10})
      $display("FAIL prio_start: got busy=%b v=%b t=%b want 1 1 10", busy, snn_req_valid, snn_req_type);
    else passed++;
    do_clear();
  endtask

  task automatic test_random();
    logic [3:0]    f;
    logic [1:0]    e, et;
    logic [DW-1:0] t, n, d;
    logic          w;
    int unsigned   rd, sd;
    do_clear();
    for (int unsigned it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       begin f = F_PRE; et = 2'b00; end
        1:       begin f = F_ENC; et = 2'b01; end
        default: begin f = F_SNN; et = 2'b10; end
      endcase
      e = 2'($urandom); t = DW'($urandom); n = DW'($urandom);
      ctrl_valid = 1'b1; funct_op = f; enc_sel = e; T = t; N = n;
      wait_snn = 1'($urandom_range(0, 1));
      tick();
      ctrl_valid = 1'b0; wait_snn = 1'b0;
      total++;
      if ({snn_req_valid, snn_req_type, snn_req_enc, snn_req_rs1, snn_req_rs2} !== {1'b1, et, e, t, n})
        $display("FAIL rnd_req[%0d]: got v=%b t=%b e=%b %h %h want 1 %b %b %h %h", it,
                 snn_req_valid, snn_req_type, snn_req_enc, snn_req_rs1, snn_req_rs2, et, e, t, n);
      else passed++;
      rd = $urandom_range(0, 3);
      for (int unsigned k = 0; k < rd; k++) begin
        T = DW'($urandom); N = DW'($urandom); enc_sel = 2'($urandom);
        snn_rsp_valid = 1'($urandom_range(0, 1)); snn_rsp_data = DW'($urandom);
        tick();
        total++;
        if ({snn_req_valid, snn_req_type, snn_req_enc, snn_req_rs1, snn_req_rs2, busy} !== {1'b1, et, e, t, n, 1'b1})
          $display("FAIL rnd_hold[%0d]: got v=%b %h %h busy=%b want 1 %h %h 1", it,
                   snn_req_valid, snn_req_rs1, snn_req_rs2, busy, t, n);
        else passed++;
      end
      snn_rsp_valid = 1'b0; snn_req_ready = 1'b1;
      tick();
      snn_req_ready = 1'b0;
      total++;
      if ({busy, snn_rsp_ready, snn_req_valid} !== 3'b110)
        $display("FAIL rnd_busy[%0d]: got %b%b%b want 110", it, busy, snn_rsp_ready, snn_req_valid);
      else passed++;
      w = 1'($urandom_range(0, 1));
      wait_snn = w;
      sd = $urandom_range(0, 5);
      for (int unsigned k = 0; k < sd; k++) begin
        #1;
        if (w) begin
          total++;
          if (cpu_stall !== 1'b1) $display("FAIL rnd_wait[%0d]: got %b want 1", it, cpu_stall);
          else passed++;
        end
        tick();
      end
      d = DW'($urandom);
      respond(d, ($urandom_range(0, 3) == 0));
      wait_snn = 1'b0;
      total++;
      if ({err_flags, busy} !== {m_err, 1'b0})
        $display("FAIL rnd_err[%0d]: got err=%b busy=%b want %b 0", it, err_flags, busy, m_err);
      else passed++;
      case ($urandom_range(0, 3))
        0, 1: begin
          output_snn = 1'b1;
          tick();
          output_snn = 1'b0;
          push_exp++;
          total++;
          if ({res_push, res_data} !== {1'b1, m_result})
            $display("FAIL rnd_push[%0d]: got %b %h want 1 %h", it, res_push, res_data, m_result);
          else passed++;
          m_pending = 1'b0;
        end
        2: ;
        default: do_clear();
      endcase
    end
  endtask

  task automatic test_busy_timeout();
    int unsigned found = 0;
    do_clear();
    go_busy(F_SNN, 2'b00, 16'h00EE, 16'h00FF);
    for (int unsigned k = 1; k <= 20; k++) begin
      tick();
      if (snn_abort === 1'b1 && found == 0) found = k;
    end
`ifdef SNN_TIMEOUT_EN
    total++;
    if (found != 8) $display("FAIL timeout_cycle: got abort after %0d want 8", found);
    else passed++;
    total++;
    if ({err_flags, busy} !== {3'b010, 1'b0})
      $display("FAIL timeout_state: got err=%b busy=%b want 010 0", err_flags, busy);
    else passed++;
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data} !== {1'b1, 16'hFFFF})
      $display("FAIL timeout_push: got %b %h want 1 ffff", res_push, res_data);
    else passed++;
    do_clear();
    go_busy(F_PRE, 2'b00, 16'h0001, 16'h0001);
    for (int unsigned k = 0; k < 7; k++) tick();
    snn_rsp_valid = 1'b1; snn_rsp_data = 16'h4242;
    tick();
    snn_rsp_valid = 1'b0;
    total++;
    if ({snn_abort, err_flags, busy} !== 5'b00000)
      $display("FAIL rsp_beats_timeout: got abort=%b err=%b busy=%b want 0 000 0", snn_abort, err_flags, busy);
    else passed++;
    output_snn = 1'b1;
    tick();
    output_snn = 1'b0;
    push_exp++;
    total++;
    if ({res_push, res_data} !== {1'b1, 16'h4242})
      $display("FAIL rsp_beats_timeout_data: got %b %h want 1 4242", res_push, res_data);
    else passed++;
`else
    total++;
    if ({found == 0, busy, err_flags} !== {1'b1, 1'b1, 3'b000})
      $display("FAIL no_timeout: got abort_at=%0d busy=%b err=%b want 0 1 000", found, busy, err_flags);
    else passed++;
`endif
    do_clear();
  endtask

  task automatic test_push_count();
    tick(); tick();
    total++;
    if (push_seen != push_exp) $display("FAIL push_count: got %0d want %0d", push_seen, push_exp);
    else passed++;
  endtask

  initial begin
    m_err = '0; m_pending = 1'b0; m_result = '0;
    test_reset();
    test_start_snn();
    test_wait_stall();
    test_output_in_req();
    test_clear();
    test_back_to_back();
    test_unknown_and_priority();
    test_random();
    test_busy_timeout();
    test_push_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/snn_cmd_dispatch.md
Name: snn_cmd_dispatch

Overview:
- Sits directly downstream of the EX stage. Consumes its SNN control strobes (ctrl_valid, clear, wait_snn, output_snn, funct_op, enc_sel) and the T/N operands.
- Runs the valid/ready request and response handshake with the SNN accelerator and buffers one result.
- Stalls the CPU pipeline when needed. Pushes the SNN result back toward the data-stack write path.

Parameters:
DATA_WIDTH, 16, operand/result width
TIMEOUT_CYCLES, 4096, max BUSY cycles before abort (used only with SNN_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
ctrl_valid  input  1  EX start strobe (START_PRE/ENC/SNN)
funct_op  input  4  EX funct_op_o; start type decoded via defines.v START_PRE/START_ENC/START_SNN
enc_sel  input  2  encoder select for START_ENC
clear  input  1  EX CLEAR strobe
wait_snn  input  1  EX WAIT_SNN strobe
output_snn  input  1  EX OUTPUT_SNN strobe
T  input  DATA_WIDTH  data stack top
N  input  DATA_WIDTH  data stack next
cpu_stall  output  1  combinational; holds PC/pipeline
res_push  output  1  registered 1-cycle pulse: push res_data onto D stack
res_data  output  DATA_WIDTH  result for push
busy  output  1  state != IDLE
err_flags  output  3  sticky: [0] rsp_err, [1] timeout, [2] result overwritten unread
snn_req_valid  output  1  request valid
snn_req_ready  input  1  accelerator accepts
snn_req_type  output  2  00 PRE, 01 ENC, 10 SNN
snn_req_enc  output  2  latched enc_sel
snn_req_rs1  output  DATA_WIDTH  latched T
snn_req_rs2  output  DATA_WIDTH  latched N
snn_abort  output  1  1-cycle abort pulse
snn_rsp_valid  input  1  response valid
snn_rsp_ready  output  1  = (state == BUSY)
snn_rsp_data  input  DATA_WIDTH  result
snn_rsp_err  input  1  response error

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; res_valid=0.
- Reset also forces all outputs 0: res_push, res_data, err_flags, snn_req_*, snn_abort, counter.
- Strobe priority if several are set in one cycle: clear > output_snn > ctrl_valid > wait_snn.
- FSM states: IDLE, REQ, BUSY.
- IDLE, ctrl_valid=1:
  - Latch type, enc_sel, T→rs1, N→rs2; go to REQ.
  - snn_req_valid=1 from the next cycle.
  - An unknown funct_op with ctrl_valid is ignored and the FSM stays IDLE.
- REQ:
  - snn_req_valid and payload held stable until snn_req_ready=1.
  - On handshake go to BUSY the next cycle and clear the counter.
  - snn_req_valid=0 in BUSY.
- BUSY:
  - snn_rsp_ready=1.
  - On rsp handshake: capture data into the result register, res_valid=1, err_flags[0] |= snn_rsp_err, go to IDLE.
  - If res_valid was already 1 at capture: overwrite and set err_flags[2].
- Start while not IDLE: cpu_stall=1 until IDLE.
  - In the first IDLE cycle, stall drops and the held strobe is accepted that same cycle.
- wait_snn: cpu_stall = (state != IDLE).
- output_snn:
  - res_valid=1: no stall. Next cycle res_push=1, res_data=result; res_valid cleared.
  - res_valid=0 and busy: stall until res_valid=1.
  - res_valid=0 and IDLE: no stall. Push 0 and set err_flags[0].
- A new start is allowed while res_valid=1; the result stays buffered.
- clear:
  - Any state → IDLE next cycle; snn_req_valid dropped; res_valid=0; err_flags=0; counter=0.
  - snn_abort pulses 1 cycle if state was REQ or BUSY.
  - cpu_stall=0.
- Mid-operation reset: identical to reset. No abort pulse; the accelerator shares the reset.

Optional Feature:
SNN_TIMEOUT_EN
- Defined:
  - Counter increments each BUSY cycle without rsp handshake.
  - On reaching TIMEOUT_CYCLES: go to IDLE, snn_abort pulse, result={DATA_WIDTH{1'b1}}, res_valid=1, err_flags[1]=1.
  - A rsp arriving in the same cycle wins over timeout.
- Undefined: no counter logic; BUSY waits indefinitely; err_flags[1] tied 0.

Test Plan:
- START_SNN strobe with T=0x0012, N=0x0034:
  - req_valid=1, rs1=0x0012, rs2=0x0034, type=10.
  - Hold req_ready=0 for 3 cycles: payload stable.
  - Then ready=1: BUSY next cycle.
- BUSY, rsp_valid=1, data=0x5A5A, err=0, then output_snn: res_push=1 one cycle later, res_data=0x5A5A, err_flags=000.
- wait_snn held during BUSY, rsp after 10 cycles:
  - cpu_stall=1 for those 10 cycles.
  - cpu_stall=0 in the first IDLE cycle.
- output_snn issued in REQ, rsp carrying 0x0007 with err=1:
  - stall until res_valid.
  - Push 0x0007, err_flags[0]=1.
- clear during BUSY: snn_abort pulse 1 cycle, busy=0 next cycle, err_flags=000; a late rsp_valid is ignored (rsp_ready=0).
- SNN_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rsp: after 8 BUSY cycles snn_abort=1, err_flags[1]=1; output_snn pushes 0xFFFF.
